stack_port_ctrl: RTL and testbench

Sequencer that drives the dual-port stack RAM (`toyblockram`, synchronous `SYNCSTACK` build) on behalf of the CPU core. It turns push/pop/peek/replace requests into RAM write and read cycles and owns the stack pointer. It returns top-of-stack (TOS) and next-on-stack (NOS) values with a valid/ready handshake and flags overflow and underflow. It sits between the core's execute stage and the stack RAM.

---
 rtl/stack_ctrl_pkg.sv | 20 ++
 rtl/stack_port_ctrl.sv | 162 ++++++++++++++++
 tb/tb_stack_port_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/stack_ctrl_pkg.sv
// Shared encodings for the stack RAM sequencer: op codes, FSM states, default depth.
package stack_ctrl_pkg;

  localparam int DEFAULT_DEPTH = 256;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_POP2 = 3'd3;
  localparam logic [2:0] OP_PEEK = 3'd4;
  localparam logic [2:0] OP_REPL = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DATA  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/stack_port_ctrl.sv
// Stack RAM sequencer: push/pop/peek/replace with TOS/NOS response, 2 cycles from accept to rsp_valid.
// One request in flight; req_ready only in IDLE, response held until rsp_ready.
module stack_port_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [31:0]   req_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_a,
  output logic [31:0]   rsp_b,
  output logic          rsp_fault,
  output logic [AW:0]   depth,
  output logic          empty,
  output logic          full,
  output logic [31:0]   ram_addr_a,
  output logic [31:0]   ram_datain_a,
  output logic          ram_wr_a,
  input  logic [31:0]   ram_data_a,
  output logic [31:0]   ram_addr_b,
  input  logic [31:0]   ram_data_b
);

  localparam logic [AW:0] DEPTH_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] D_ONE     = (AW+1)'(1);
  localparam logic [AW:0] D_TWO     = (AW+1)'(2);

  state_t        state, next_state;
  logic [2:0]    op_q;
  logic [31:0]   data_q;
  logic          fault_q;
  logic          nos_zero_q;
  logic [AW:0]   depth_q;

  logic          fault_calc;
  logic          nos_zero_calc;
  logic [AW-1:0] top_addr, tos_addr, nos_addr;
  logic [AW-1:0] addr_a, addr_b;

  assign depth     = depth_q;
  assign empty     = (depth_q == '0);
  assign full      = (depth_q == DEPTH_MAX);
  assign rsp_valid = (state == ST_RESP);

  assign top_addr = depth_q[AW-1:0];
  assign tos_addr = depth_q[AW-1:0] - AW'(1);
  assign nos_addr = depth_q[AW-1:0] - AW'(2);

  assign ram_addr_a = {{(32-AW){1'b0}}, addr_a};
  assign ram_addr_b = {{(32-AW){1'b0}}, addr_b};

  // Decided at accept time against the pre-op depth, which cannot move until ISSUE ends.
  always_comb begin
    fault_calc    = 1'b0;
    nos_zero_calc = 1'b0;
    case (req_op)
      OP_NOP:  fault_calc = 1'b0;
      OP_PUSH: begin
        fault_calc    = full;
        nos_zero_calc = empty;
      end
      OP_POP, OP_PEEK, OP_REPL: begin
        fault_calc    = empty;
        nos_zero_calc = (depth_q < D_TWO);
      end
      OP_POP2: fault_calc = (depth_q < D_TWO);
      default: fault_calc = 1'b1;
    endcase
  end

  always_comb begin
    next_state   = state;
    req_ready    = 1'b0;
    ram_wr_a     = 1'b0;
    ram_datain_a = '0;
    addr_a       = '0;
    addr_b       = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        next_state = ST_DATA;
        case (op_q)
          OP_PUSH: begin
            addr_a       = top_addr;
            addr_b       = tos_addr;
            ram_datain_a = data_q;
            ram_wr_a     = !fault_q;
          end
          OP_POP, OP_POP2, OP_PEEK: begin
            addr_a = tos_addr;
            addr_b = nos_addr;
          end
          OP_REPL: begin
            addr_a       = tos_addr;
            addr_b       = nos_addr;
            ram_datain_a = data_q;
            ram_wr_a     = !fault_q;
          end
          default: ;
        endcase
      end
      ST_DATA: next_state = ST_RESP;
      ST_RESP: if (rsp_ready) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_NOP;
      data_q     <= '0;
      fault_q    <= 1'b0;
      nos_zero_q <= 1'b0;
      depth_q    <= '0;
      rsp_a      <= '0;
      rsp_b      <= '0;
      rsp_fault  <= 1'b0;
    end else begin
      if (state == ST_IDLE && req_valid) begin
        op_q       <= req_op;
        data_q     <= req_data;
        fault_q    <= fault_calc;
        nos_zero_q <= nos_zero_calc;
      end
      if (state == ST_ISSUE && !fault_q) begin
        case (op_q)
          OP_PUSH: depth_q <= depth_q + D_ONE;
          OP_POP:  depth_q <= depth_q - D_ONE;
          OP_POP2: depth_q <= depth_q - D_TWO;
          default: ;
        endcase
      end
      // Write-first port A already reflects the new value for PUSH/REPL.
      if (state == ST_DATA) begin
        rsp_fault <= fault_q;
        if (fault_q || op_q == OP_NOP) begin
          rsp_a <= '0;
          rsp_b <= '0;
        end else begin
          rsp_a <= ram_data_a;
          rsp_b <= nos_zero_q ? 32'd0 : ram_data_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_stack_port_ctrl.sv
// Directed bench for stack_port_ctrl with a write-first synchronous dual-port RAM model.
module tb_stack_port_ctrl;
  import stack_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_fault;
  logic [2:0]  req_op;
  logic [31:0] req_data, rsp_a, rsp_b;
  logic [8:0]  depth;
  logic        empty, full;
  logic [31:0] ram_addr_a, ram_datain_a, ram_data_a, ram_addr_b, ram_data_b;
  logic        ram_wr_a;

  logic [31:0] mem [0:255];
  int          wr_count = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  stack_port_ctrl #(.DEPTH(256), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_b(rsp_b),
    .rsp_fault(rsp_fault), .depth(depth), .empty(empty), .full(full),
    .ram_addr_a(ram_addr_a), .ram_datain_a(ram_datain_a), .ram_wr_a(ram_wr_a),
    .ram_data_a(ram_data_a), .ram_addr_b(ram_addr_b), .ram_data_b(ram_data_b)
  );

  // RAM model: registered outputs, port A write-first, never reset.
  always @(posedge clk) begin
    if (ram_wr_a) begin
      mem[ram_addr_a[7:0]] <= ram_datain_a;
      ram_data_a           <= ram_datain_a;
      wr_count             <= wr_count + 1;
    end else begin
      ram_data_a <= mem[ram_addr_a[7:0]];
    end
    ram_data_b <= mem[ram_addr_b[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] d,
                       input logic [31:0] exp_a, input logic [31:0] exp_b,
                       input logic exp_f, input int hold);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    req_op    = op;
    req_data  = d;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " latency"}, 32'(n), 32'd2);
    check({tag, " rsp_a"}, rsp_a, exp_a);
    check({tag, " rsp_b"}, rsp_b, exp_b);
    check({tag, " rsp_fault"}, 32'(rsp_fault), 32'(exp_f));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " stall rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " stall rsp_a"}, rsp_a, exp_a);
      check({tag, " stall rsp_b"}, rsp_b, exp_b);
      check({tag, " stall req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_snap;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = OP_NOP;
    req_data  = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst depth", 32'(depth), 32'd0);
    check("rst empty", 32'(empty), 32'd1);
    check("rst full", 32'(full), 32'd0);
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_fault", 32'(rsp_fault), 32'd0);
    check("rst rsp_a", rsp_a, 32'd0);
    check("rst rsp_b", rsp_b, 32'd0);
    check("rst ram_wr_a", 32'(ram_wr_a), 32'd0);
    check("rst addr_a", ram_addr_a, 32'd0);
    check("rst addr_b", ram_addr_b, 32'd0);
    check("rst datain", ram_datain_a, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("push11", OP_PUSH, 32'h11, 32'h11, 32'h0, 1'b0, 0);
    do_op("push22", OP_PUSH, 32'h22, 32'h22, 32'h11, 1'b0, 0);
    do_op("peek", OP_PEEK, 32'h0, 32'h22, 32'h11, 1'b0, 0);
    check("depth after peek", 32'(depth), 32'd2);
    check("ram0", mem[0], 32'h11);
    check("ram1", mem[1], 32'h22);

    do_op("pop2", OP_POP2, 32'h0, 32'h22, 32'h11, 1'b0, 0);
    check("depth after pop2", 32'(depth), 32'd0);
    do_op("pop empty", OP_POP, 32'h0, 32'h0, 32'h0, 1'b1, 0);
    check("empty after pop fault", 32'(empty), 32'd1);

    do_op("push11 b", OP_PUSH, 32'h11, 32'h11, 32'h0, 1'b0, 0);
    do_op("repl99", OP_REPL, 32'h99, 32'h99, 32'h0, 1'b0, 0);
    check("ram0 repl", mem[0], 32'h99);
    check("depth after repl", 32'(depth), 32'd1);
    do_op("push55", OP_PUSH, 32'h55, 32'h55, 32'h99, 1'b0, 0);
    do_op("pop d2", OP_POP, 32'h0, 32'h55, 32'h99, 1'b0, 0);
    do_op("pop d1", OP_POP, 32'h0, 32'h99, 32'h0, 1'b0, 0);
    check("depth after pops", 32'(depth), 32'd0);

    do_op("pushA", OP_PUSH, 32'hA, 32'hA, 32'h0, 1'b0, 0);
    do_op("pushB", OP_PUSH, 32'hB, 32'hB, 32'hA, 1'b0, 0);
    do_op("peek stall", OP_PEEK, 32'h0, 32'hB, 32'hA, 1'b0, 5);
    wr_snap = wr_count;
    do_op("op7", 3'd7, 32'h1234, 32'h0, 32'h0, 1'b1, 0);
    check("op7 no write", 32'(wr_count), 32'(wr_snap));
    check("op7 depth", 32'(depth), 32'd2);
    do_op("pop d2 b", OP_POP, 32'h0, 32'hB, 32'hA, 1'b0, 0);
    do_op("pop2 d1", OP_POP2, 32'h0, 32'h0, 32'h0, 1'b1, 0);
    check("pop2 fault depth", 32'(depth), 32'd1);

    req_op    = OP_PUSH;
    req_data  = 32'h77;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("issue ram_wr_a", 32'(ram_wr_a), 32'd1);
    check("issue addr_a", ram_addr_a, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort depth", 32'(depth), 32'd0);
    check("abort rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort ram_wr_a", 32'(ram_wr_a), 32'd0);
    check("abort req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("abort depth next", 32'(depth), 32'd0);
    check("abort rsp_valid next", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 256; i++)
      do_op("fill", OP_PUSH, 32'(i), 32'(i), (i == 0) ? 32'd0 : 32'(i - 1), 1'b0, 0);
    check("full flag", 32'(full), 32'd1);
    check("full depth", 32'(depth), 32'd256);
    wr_snap = wr_count;
    do_op("push full", OP_PUSH, 32'hDEAD, 32'h0, 32'h0, 1'b1, 0);
    check("full after fault", 32'(full), 32'd1);
    check("depth after fault", 32'(depth), 32'd256);
    check("no write on full", 32'(wr_count), 32'(wr_snap));
    for (int i = 0; i < 256; i++)
      check("ram fill", mem[i], 32'(i));
    do_op("peek full", OP_PEEK, 32'h0, 32'd255, 32'd254, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
